// File: rtl/restador_serie_param.sv
// Bit-serial subtractor/adder: one bit per clock, LSB first, through a registered borrow/carry flop.
// Optional `SATURACION_EN clamps R to the signed limit on overflow instead of wrapping.
module restador_serie_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Inicio,
    input  logic             Modo,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             AcarreoEntrada,
    output logic [WIDTH-1:0] R,
    output logic             AcarreoSalida,
    output logic             Desbordamiento,
    output logic             Ocupado,
    output logic             Listo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] LIM_NEG = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] LIM_POS = ~LIM_NEG;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] x_reg, y_reg, sr_reg, sr_next, result;
    logic             mode_reg, b_reg, b_next, d, x_bit, y_bit, ovf;
    logic [WIDTH-1:0] r_reg;
    logic             cout_reg, ovf_reg;
    logic             accept, last;

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Inicio) state_next = CALC;
            CALC:    if (cnt_reg == LAST) state_next = DONE;
            DONE:    state_next = Inicio ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept = Inicio && (state_reg == IDLE || state_reg == DONE);
    assign last   = (state_reg == CALC) && (cnt_reg == LAST);

    assign x_bit  = x_reg[cnt_reg];
    assign y_bit  = y_reg[cnt_reg];
    assign d      = x_bit ^ y_bit ^ b_reg;
    assign b_next = mode_reg ? ((x_bit & y_bit) | (x_bit & b_reg) | (y_bit & b_reg))
                             : ((~x_bit & y_bit) | (~x_bit & b_reg) | (y_bit & b_reg));
    // On the MSB step b_reg is the borrow/carry into the MSB and b_next the one out of it.
    assign ovf    = b_reg ^ b_next;

    always_comb begin
        sr_next          = sr_reg;
        sr_next[cnt_reg] = d;
    end

`ifdef SATURACION_EN
    assign result = ovf ? (x_reg[WIDTH-1] ? LIM_NEG : LIM_POS) : sr_next;
`else
    assign result = sr_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            sr_reg   <= '0;
            mode_reg <= 1'b0;
            b_reg    <= 1'b0;
            r_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            cnt_reg  <= '0;
            x_reg    <= X;
            y_reg    <= Y;
            sr_reg   <= '0;
            mode_reg <= Modo;
            b_reg    <= AcarreoEntrada;
        end else if (state_reg == CALC) begin
            cnt_reg <= cnt_reg + 1'b1;
            sr_reg  <= sr_next;
            b_reg   <= b_next;
            if (last) begin
                r_reg    <= result;
                cout_reg <= b_next;
                ovf_reg  <= ovf;
            end
        end
    end

    assign R              = r_reg;
    assign AcarreoSalida  = cout_reg;
    assign Desbordamiento = ovf_reg;
    assign Ocupado        = (state_reg == CALC);
    assign Listo          = (state_reg == DONE);
endmodule
